// File: rtl/npu_pkg.sv
// Types shared across the NPU datapath blocks.
package npu_pkg;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } packer_state_t;

endpackage

// File: rtl/width.svh
// Shared datapath widths for the NPU blocks.
`ifndef WIDTH_SVH
`define WIDTH_SVH
`define DATA_WIDTH 8
`endif

// File: rtl/vector_packer.sv
// Collects a stream of (x, w) element pairs into N-lane vectors for the dot-product stage.
// A vector closes at lane N-1 or on in_last; short vectors are zero-padded.
`include "width.svh"

module vector_packer
   import npu_pkg::*;
#(
   parameter int N          = 4,
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [DATA_WIDTH-1:0]        in_x,
   input  logic signed [DATA_WIDTH-1:0]        in_w,
   input  logic                                in_last,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic signed [N*DATA_WIDTH-1:0]      x,
   output logic signed [N*DATA_WIDTH-1:0]      w,
   output logic        [$clog2(N+1)-1:0]       out_count
);

   localparam int LW = $clog2(N);
   localparam int CW = $clog2(N+1);

   packer_state_t                state;
   logic        [LW-1:0]         lane;
   logic        [CW-1:0]         held_count;
   logic signed [DATA_WIDTH-1:0] fill_x  [N];
   logic signed [DATA_WIDTH-1:0] fill_w  [N];
   logic signed [DATA_WIDTH-1:0] out_x   [N];
   logic signed [DATA_WIDTH-1:0] out_w   [N];
   logic signed [DATA_WIDTH-1:0] close_x [N];
   logic signed [DATA_WIDTH-1:0] close_w [N];

   logic in_fire;
   logic out_fire;
   logic closing;
   logic out_free;

   assign in_ready = (state == FILL);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign closing  = in_fire && (in_last || (lane == LW'(N-1)));
   assign out_free = !out_valid || out_ready;

   // The vector as it looks once the current element lands: lanes above it read as zero
   // so an early-closed vector contributes nothing extra to the dot product.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      close_x = '{default: '0};
      close_w = '{default: '0};
      for (int i = 0; i < N; i++) begin
         if (LW'(i) < lane) begin
            close_x[i] = fill_x[i];
            close_w[i] = fill_w[i];
         end else if (LW'(i) == lane) begin
            close_x[i] = in_x;
            close_w[i] = in_w;
         end
      end
   end

   // NOTE: the fill buffer carries no reset; it is only ever read below the lane index,
   // and lanes above it are masked when a vector closes.
   always_ff @(posedge clk) begin
      if (in_fire && !closing) begin
         fill_x[lane] <= in_x;
         fill_w[lane] <= in_w;
      end else if (closing && !out_free) begin
         fill_x <= close_x;
         fill_w <= close_w;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         lane       <= '0;
         held_count <= '0;
         out_valid  <= 1'b0;
         out_count  <= '0;
         out_x      <= '{default: '0};
         out_w      <= '{default: '0};
      end else begin
         case (state)
            FILL: begin
               if (in_fire) begin
                  lane <= closing ? '0 : lane + LW'(1);
               end
               if (closing && out_free) begin
                  out_x     <= close_x;
                  out_w     <= close_w;
                  out_count <= CW'(lane) + CW'(1);
                  out_valid <= 1'b1;
               end else if (closing) begin
                  held_count <= CW'(lane) + CW'(1);
                  state      <= STALL;
               end else if (out_fire) begin
                  out_valid <= 1'b0;
               end
            end
            STALL: begin
               // The output register is always occupied here, so out_ready alone means a drain.
               if (out_ready) begin
                  out_x     <= fill_x;
                  out_w     <= fill_w;
                  out_count <= held_count;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   always_comb begin
      x = '0;
      w = '0;
      for (int i = 0; i < N; i++) begin
         x[i*DATA_WIDTH +: DATA_WIDTH] = out_x[i];
         w[i*DATA_WIDTH +: DATA_WIDTH] = out_w[i];
      end
   end

endmodule
